icache: RTL and testbench

Direct-mapped, read-only instruction cache between the CPU's PC/INSTRUCTION fetch port and the 1024-byte instruction memory. It replaces the combinational fetch path. It serves hits with no stall and, on a miss, stalls the CPU via BUSYWAIT while it fetches a 16-byte block from the slow memory through a request/busywait handshake. Valid, tag and data arrays live here; the memory behind it is block-addressed.

---
 rtl/icache_pkg.sv | 17 +
 rtl/icache_ctrl.sv | 52 +++++
 rtl/icache.sv | 105 ++++++++++
 tb/tb_icache.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/icache_pkg.sv
// Shared types and geometry for the direct-mapped instruction cache.
package icache_pkg;

  typedef enum logic [1:0] {
    IDLE,
    MEM_READ,
    UPDATE
  } state_t;

  localparam int LINE_BYTES     = 16;
  localparam int OFFSET_BITS    = 4;
  localparam int DEF_INDEX_BITS = 3;
  localparam int DEF_ADDR_BITS  = 10;
  localparam int TAG_BITS       = DEF_ADDR_BITS - DEF_INDEX_BITS - OFFSET_BITS;
  localparam int BLK_ADDR_BITS  = DEF_ADDR_BITS - OFFSET_BITS;

endpackage

// File: rtl/icache_ctrl.sv
// Miss-handling FSM: issues the block read, waits out mem_busywait, then
// requests a one-cycle line fill.
module icache_ctrl
  import icache_pkg::*;
#(
  parameter int BLK_W = BLK_ADDR_BITS
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             hit,
  input  logic [BLK_W-1:0] blk_addr,
  input  logic             mem_busywait,
  output logic             mem_read,
  output logic [BLK_W-1:0] mem_address,
  output logic             capture,
  output logic             fill_en,
  output logic             idle
);

  state_t state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      mem_read    <= 1'b0;
      mem_address <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!hit) begin
            state       <= MEM_READ;
            mem_read    <= 1'b1;
            mem_address <= blk_addr;
          end
        end
        MEM_READ: begin
          if (!mem_busywait) begin
            state    <= UPDATE;
            mem_read <= 1'b0;
          end
        end
        UPDATE:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign capture = (state == MEM_READ) && !mem_busywait;
  assign fill_en = (state == UPDATE);
  assign idle    = (state == IDLE);

endmodule

// File: rtl/icache.sv
// Direct-mapped read-only instruction cache with a block-read memory port.
// Optional hit/miss counters are enabled by defining ICACHE_STATS_EN.
module icache
  import icache_pkg::*;
#(
  parameter int INDEX_BITS = DEF_INDEX_BITS,
  parameter int ADDR_BITS  = DEF_ADDR_BITS
) (
  input  logic                       CLK,
  input  logic                       RESET,
  input  logic [31:0]                PC,
  output logic [31:0]                INSTRUCTION,
  output logic                       BUSYWAIT,
  output logic                       mem_read,
  output logic [ADDR_BITS-5:0]       mem_address,
  input  logic [LINE_BYTES*8-1:0]    mem_readdata,
  input  logic                       mem_busywait
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0]                hit_count,
  output logic [31:0]                miss_count
`endif
);

  localparam int LINES = 1 << INDEX_BITS;
  localparam int TAG_W = ADDR_BITS - INDEX_BITS - OFFSET_BITS;
  localparam int BLK_W = ADDR_BITS - OFFSET_BITS;

  logic [LINE_BYTES*8-1:0] data_array [LINES];
  logic [TAG_W-1:0]        tag_array  [LINES];
  logic [LINES-1:0]        valid;
  logic [LINE_BYTES*8-1:0] fill_line;

  logic [INDEX_BITS-1:0] index;
  logic [TAG_W-1:0]      tag;
  logic [1:0]            word_sel;
  logic                  hit, capture, fill_en, idle;
  logic [LINE_BYTES*8-1:0] line;
  logic [31:0]           word;
  logic                  unused_pc;

  assign index     = PC[OFFSET_BITS+INDEX_BITS-1:OFFSET_BITS];
  assign tag       = PC[ADDR_BITS-1:OFFSET_BITS+INDEX_BITS];
  assign word_sel  = PC[3:2];
  assign unused_pc = ^{PC[31:ADDR_BITS], PC[1:0]};
  assign hit       = valid[index] && (tag_array[index] == tag);
  assign BUSYWAIT  = !idle || !hit;

  icache_ctrl #(.BLK_W(BLK_W)) u_ctrl (
    .clk          (CLK),
    .rst_n        (RESET),
    .hit          (hit),
    .blk_addr     ({tag, index}),
    .mem_busywait (mem_busywait),
    .mem_read     (mem_read),
    .mem_address  (mem_address),
    .capture      (capture),
    .fill_en      (fill_en),
    .idle         (idle)
  );

  // Big-endian word assembly: byte 4w of the line lands in bits [31:24].
  always_comb begin
    line = data_array[index];
    word = '0;
    for (int unsigned b = 0; b < 4; b++)
      word[31-8*b -: 8] = line[(4*int'(word_sel)+int'(b))*8 +: 8];
    INSTRUCTION = hit ? word : '0;
  end

  always_ff @(posedge CLK) begin
    if (capture) fill_line <= mem_readdata;
    if (fill_en) begin
      data_array[mem_address[INDEX_BITS-1:0]] <= fill_line;
      tag_array[mem_address[INDEX_BITS-1:0]]  <= mem_address[BLK_W-1:INDEX_BITS];
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET)       valid <= '0;
    else if (fill_en) valid[mem_address[INDEX_BITS-1:0]] <= 1'b1;
  end

`ifdef ICACHE_STATS_EN
  logic [ADDR_BITS-1:0] last_pc;
  logic                 hit_ev, miss_ev;

  // A miss also marks its PC as counted so the post-fill hit is not a new access.
  assign miss_ev = idle && !hit;
  assign hit_ev  = idle && hit && (PC[ADDR_BITS-1:0] != last_pc);

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      hit_count  <= '0;
      miss_count <= '0;
      last_pc    <= '0;
    end else begin
      if (hit_ev || miss_ev) last_pc <= PC[ADDR_BITS-1:0];
      if (hit_ev && hit_count != '1)   hit_count  <= hit_count + 32'd1;
      if (miss_ev && miss_count != '1) miss_count <= miss_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_icache.sv
// Scoreboard bench for icache: fetches push expected words, a negedge monitor
// pops and compares whenever BUSYWAIT is low.
module tb_icache;

  logic         CLK = 1'b0;
  logic         RESET;
  logic [31:0]  PC;
  logic [31:0]  INSTRUCTION;
  logic         BUSYWAIT;
  logic         mem_read;
  logic [5:0]   mem_address;
  logic [127:0] mem_readdata;
  logic         mem_busywait;
`ifdef ICACHE_STATS_EN
  logic [31:0]  hit_count, miss_count;
`endif

  icache #(.INDEX_BITS(3), .ADDR_BITS(10)) dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .PC           (PC),
    .INSTRUCTION  (INSTRUCTION),
    .BUSYWAIT     (BUSYWAIT),
    .mem_read     (mem_read),
    .mem_address  (mem_address),
    .mem_readdata (mem_readdata),
    .mem_busywait (mem_busywait)
`ifdef ICACHE_STATS_EN
    ,
    .hit_count    (hit_count),
    .miss_count   (miss_count)
`endif
  );

  always #5 CLK = ~CLK;

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] exp_q[$];
  bit          active = 0;

  // Slow memory: ready in the mem_lat-th cycle of a request.
  int mem_lat = 5;
  int mcnt = 0;

  always @(posedge CLK) begin
    if (!mem_read) mcnt <= 0;
    else           mcnt <= mcnt + 1;
  end

  assign mem_busywait = mem_read && (mcnt < mem_lat - 1);

  function automatic logic [7:0] mem_byte(input logic [9:0] a);
    return (a[7:0] + {a[9:8], 6'h00}) ^ 8'h5A;
  endfunction

  always_comb begin
    mem_readdata = '0;
    for (int i = 0; i < 16; i++)
      mem_readdata[8*i +: 8] = mem_byte({mem_address, 4'(i)});
  end

  function automatic logic [31:0] exp_word(input logic [31:0] pc);
    logic [9:0] a;
    a = {pc[9:2], 2'b00};
    return {mem_byte(a), mem_byte(a + 10'd1), mem_byte(a + 10'd2), mem_byte(a + 10'd3)};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  always @(negedge CLK) begin
    if (active && RESET === 1'b1 && BUSYWAIT === 1'b0) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_output: got %h, expected no output", INSTRUCTION);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        if (INSTRUCTION !== e) begin
          n_err++;
          $display("FAIL instruction: got %h, expected %h (PC=%h)", INSTRUCTION, e, PC);
        end
      end
    end
  end

  // One fetch: busy cycles, mem_read cycles and requested block address are checked.
  task automatic fetch(input logic [31:0] pc, input int exp_busy, input int exp_mr,
                       input logic [5:0] exp_addr);
    int         busy, mr;
    bit         done;
    logic [5:0] addr;
    @(posedge CLK);
    #1;
    RESET  = 1'b1;
    PC     = pc;
    active = 1'b1;
    exp_q.push_back(exp_word(pc));
    busy = 0; mr = 0; done = 0; addr = '0;
    for (int c = 0; c < 200 && !done; c++) begin
      @(negedge CLK);
      if (!BUSYWAIT) done = 1;
      else begin
        busy++;
        if (mem_read) begin
          mr++;
          addr = mem_address;
        end
      end
    end
    if (!done) begin
      n_vec++;
      n_err++;
      $display("FAIL fetch_timeout: got BUSYWAIT=1 for 200 cycles, expected release (PC=%h)", pc);
      void'(exp_q.pop_back());
    end
    chk("busy_cycles", 32'(busy), 32'(exp_busy));
    chk("mem_read_cycles", 32'(mr), 32'(exp_mr));
    chk("mem_read_on_hit", {31'd0, mem_read}, 32'd0);
    if (exp_mr > 0) chk("mem_address", {26'd0, addr}, {26'd0, exp_addr});
    #1 active = 1'b0;
  endtask

  initial begin
    bit seen;
    RESET = 1'b0;
    PC    = 32'd0;
    #1;
    chk("rst_busywait", {31'd0, BUSYWAIT}, 32'd1);
    chk("rst_mem_read", {31'd0, mem_read}, 32'd0);
    chk("rst_mem_address", {26'd0, mem_address}, 32'd0);
    chk("rst_instruction", INSTRUCTION, 32'd0);
`ifdef ICACHE_STATS_EN
    chk("rst_hit_count", hit_count, 32'd0);
    chk("rst_miss_count", miss_count, 32'd0);
`endif
    repeat (2) @(posedge CLK);

    // Cold miss, spatial hits, conflict eviction.
    fetch(32'd0,   7, 5, 6'd0);
    fetch(32'd4,   0, 0, 6'd0);
    fetch(32'd8,   0, 0, 6'd0);
    fetch(32'd12,  0, 0, 6'd0);
    fetch(32'd128, 7, 5, 6'd8);
    fetch(32'd0,   7, 5, 6'd0);
`ifdef ICACHE_STATS_EN
    chk("miss_count", miss_count, 32'd3);
    chk("hit_count", hit_count, 32'd3);
`endif
    // Upper PC bits and PC[1:0] ignored: hits line 0, word 0.
    fetch(32'hFFFF_FC03, 0, 0, 6'd0);

    // Single-cycle memory.
    mem_lat = 1;
    fetch(32'h0000_0010, 3, 1, 6'd1);
    fetch(32'h0000_001C, 0, 0, 6'd0);

    // Back-to-back misses.
    mem_lat = 5;
    fetch(32'h0000_0020, 7, 5, 6'd2);
    fetch(32'h0000_03B4, 7, 5, 6'h3B);
    fetch(32'h0000_0024, 0, 0, 6'd0);

    // Reset during MEM_READ drops the request; same PC misses again.
    @(posedge CLK);
    #1 PC = 32'h0000_0048;
    seen = 0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge CLK);
      if (mem_read) seen = 1;
    end
    chk("midfill_req_seen", {31'd0, seen}, 32'd1);
    #1 RESET = 1'b0;
    #1;
    chk("midfill_mem_read", {31'd0, mem_read}, 32'd0);
    chk("midfill_busywait", {31'd0, BUSYWAIT}, 32'd1);
    @(posedge CLK);
    fetch(32'h0000_0048, 7, 5, 6'd4);
    fetch(32'h0000_0000, 7, 5, 6'd0);

    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no completion, expected finish");
    $fatal(1, "timeout");
  end

endmodule
